multicycle_control_fsm: RTL

//  Parametrised multi-cycle control unit for the 16-bit CR16-style core; successor to the single-state ControlLogic.

---
 rtl/multicycle_control_fsm.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit for the 16-bit CR16-style core: sequences fetch, decode,
// execute, memory and writeback, with a memory-ready timeout and sticky halt/bus-error.
module multicycle_control_fsm #(
  parameter int INSTR_W    = 16,
  parameter int REG_ADDR_W = 4,
  parameter int FLAG_W     = 5,
  parameter int TIMEOUT    = 16,
  parameter int TIMEOUT_W  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INSTR_W-1:0]    instruction,
  input  logic [FLAG_W-1:0]     flags,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_sel,
  output logic                  ir_load,
  output logic                  pc_en,
  output logic [1:0]            pc_sel,
  output logic                  reg_we,
  output logic [1:0]            wb_sel,
  output logic [3:0]            alu_op,
  output logic [3:0]            alu_ext,
  output logic                  reg_or_imm,
  output logic [7:0]            imm,
  output logic [REG_ADDR_W-1:0] r_dest,
  output logic [REG_ADDR_W-1:0] r_src,
  output logic                  halted,
  output logic                  bus_error,
  output logic                  illegal,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam bit                   TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST  = TIMEOUT_EN ? TIMEOUT_W'(TIMEOUT - 1) : '0;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 halted_q, bus_error_q;
  logic                 set_berr;

  logic [3:0] op_f, rd_f, ext_f, rs_f;
  logic       is_halt_ins, is_stor, wait_expired;

  assign op_f  = ir_q[INSTR_W-1  -: 4];
  assign rd_f  = ir_q[INSTR_W-5  -: 4];
  assign ext_f = ir_q[INSTR_W-9  -: 4];
  assign rs_f  = ir_q[INSTR_W-13 -: 4];

  assign is_halt_ins  = (ir_q == {INSTR_W{1'b1}});
  assign is_stor      = (ext_f == 4'b0100);
  assign wait_expired = TIMEOUT_EN && (cnt_q == WAIT_LAST);

  assign alu_op    = op_f;
  assign alu_ext   = ext_f;
  assign imm       = {ext_f, rs_f};
  assign r_dest    = REG_ADDR_W'(rd_f);
  assign r_src     = REG_ADDR_W'(rs_f);
  assign halted    = halted_q;
  assign bus_error = bus_error_q;
  assign dbg_state = state_q;

  // Flag bit map {N,Z,F,L,C}; only the low five bits take part.
  function automatic logic cond_true(input logic [3:0] code, input logic [4:0] f);
    logic n, z, fl, l, c;
    n  = f[4];
    z  = f[3];
    fl = f[2];
    l  = f[1];
    c  = f[0];
    case (code)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return c;
      4'h3:    return !c;
      4'h4:    return l;
      4'h5:    return !l;
      4'h6:    return n;
      4'h7:    return !n;
      4'h8:    return fl;
      4'h9:    return !fl;
      4'hA:    return !l && !z;
      4'hB:    return l || z;
      4'hC:    return !n && !z;
      4'hD:    return n || z;
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    set_berr   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = 2'd0;
    reg_we     = 1'b0;
    wb_sel     = 2'd0;
    reg_or_imm = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          set_berr = 1'b1;
          state_d  = S_HALT;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end

      S_DECODE: state_d = is_halt_ins ? S_HALT : S_EXECUTE;

      S_EXECUTE: begin
        state_d = S_FETCH;
        case (op_f)
          4'h0: begin
            reg_we = 1'b1;
            pc_en  = 1'b1;
          end
          4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hD: begin
            reg_we     = 1'b1;
            reg_or_imm = 1'b1;
            pc_en      = 1'b1;
          end
          4'hB: begin
            reg_or_imm = 1'b1;
            pc_en      = 1'b1;
          end
          4'h4: begin
            case (ext_f)
              4'b0000, 4'b0100: state_d = S_MEM;
              4'b1000: begin
                reg_we = 1'b1;
                wb_sel = 2'd2;
                pc_en  = 1'b1;
                pc_sel = 2'd2;
              end
              4'b1100: begin
                pc_en  = 1'b1;
                pc_sel = cond_true(rd_f, flags[4:0]) ? 2'd2 : 2'd0;
              end
              default: begin
                illegal = 1'b1;
                pc_en   = 1'b1;
              end
            endcase
          end
          4'hC: begin
            pc_en  = 1'b1;
            pc_sel = cond_true(rd_f, flags[4:0]) ? 2'd1 : 2'd0;
          end
          default: begin
            illegal = 1'b1;
            pc_en   = 1'b1;
          end
        endcase
      end

      // A store retires in its ready cycle; a load needs the writeback cycle.
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_stor;
        if (mem_ready) begin
          if (is_stor) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_expired) begin
          set_berr = 1'b1;
          state_d  = S_HALT;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end

      S_WRITEBACK: begin
        reg_we  = 1'b1;
        wb_sel  = 2'd1;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Reset silences every strobe, including a request still outstanding.
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_load    = 1'b0;
      pc_en      = 1'b0;
      pc_sel     = 2'd0;
      reg_we     = 1'b0;
      wb_sel     = 2'd0;
      reg_or_imm = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FETCH;
      ir_q        <= '0;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ir_load) ir_q <= instruction;
      if (state_d == S_HALT) halted_q <= 1'b1;
      if (set_berr) bus_error_q <= 1'b1;
    end
  end

endmodule
